// File: rtl/ioctl_sdram_loader.sv
// ioctl_sdram_loader: routes hps_io downloads either into a byte FIFO drained to SDRAM or into
// a DIP switch bank, then shares the single SDRAM port with graphics reads once loading is done.
// Optional feature: define LOADER_CHECKSUM_EN to build the 16-bit ROM byte sum on rom_sum.
module ioctl_sdram_loader #(
  parameter int unsigned ADDR_W    = 25,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ROM_INDEX = 0,
  parameter int unsigned DIP_INDEX = 254,
  parameter int unsigned DIP_BYTES = 8
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   ioctl_download,
  input  logic [7:0]             ioctl_index,
  input  logic                   ioctl_wr,
  input  logic [ADDR_W-1:0]      ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  output logic                   ioctl_wait,
  output logic [8*DIP_BYTES-1:0] dip_out,
  input  logic                   gfx_read,
  input  logic [ADDR_W-1:0]      gfx_addr,
  output logic [7:0]             gfx_data,
  output logic                   gfx_valid,
  output logic [ADDR_W-1:0]      sd_addr,
  output logic [7:0]             sd_din,
  output logic                   sd_we,
  output logic                   sd_rd,
  input  logic [7:0]             sd_dout,
  input  logic                   sd_ready,
  output logic                   core_reset,
  output logic                   rom_loaded,
  output logic                   overflow,
  output logic [15:0]            rom_sum
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

  state_e                 state_q;
  logic                   sd_we_q, sd_rd_q, gfx_valid_q;
  logic [ADDR_W-1:0]      sd_addr_q;
  logic [7:0]             sd_din_q, gfx_data_q;

  logic [ADDR_W-1:0]      fifo_addr_q [DEPTH];
  logic [7:0]             fifo_data_q [DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   pend_q, pend_d;
  logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
  logic                   core_reset_q, core_reset_d;
  logic                   dl_q;
  logic                   rom_active_q, rom_active_d;
  logic                   rom_loaded_q, rom_loaded_d;
  logic [8*DIP_BYTES-1:0] dip_q, dip_d;

  logic rom_sel, dip_sel, full, empty, push, pop, rd_issue, rom_start, rom_done;

  // Routing, FIFO bookkeeping and flag next-state
  always_comb begin
    rom_sel   = ioctl_wr & ioctl_download & (ioctl_index == 8'(ROM_INDEX));
    dip_sel   = ioctl_wr & ioctl_download & (ioctl_index == 8'(DIP_INDEX)) &
                (ioctl_addr < ADDR_W'(DIP_BYTES));
    full      = (count_q == CntW'(DEPTH));
    empty     = (count_q == '0);
    push      = rom_sel & ~full;
    pop       = (state_q == StWr) & sd_ready;
    rd_issue  = (state_q == StIdle) & empty & pend_q;
    rom_start = ioctl_download & ~dl_q & (ioctl_index == 8'(ROM_INDEX));
    rom_done  = rom_active_q & ~ioctl_download & empty & (state_q == StIdle);

    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end

    // A dropped push is still flagged even if a pop frees a slot in the same cycle
    overflow_d = overflow_q | (rom_sel & full);

    // Latest request wins; a request landing during issue arms a second access
    pend_d    = gfx_read | (pend_q & ~rd_issue);
    rd_addr_d = gfx_read ? gfx_addr : rd_addr_q;

    core_reset_d = ioctl_download | ~empty | (state_q == StWr);

    rom_active_d = rom_start ? 1'b1 : (rom_done ? 1'b0 : rom_active_q);
    rom_loaded_d = rom_start ? 1'b0 : (rom_done ? 1'b1 : rom_loaded_q);

    dip_d = dip_q;
    if (dip_sel) begin
      for (int unsigned k = 0; k < DIP_BYTES; k++) begin
        if (ioctl_addr == ADDR_W'(k)) dip_d[8*k +: 8] = ioctl_dout;
      end
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= ioctl_addr;
      fifo_data_q[wr_ptr_q] <= ioctl_dout;
    end
  end

  // Datapath and flag registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      pend_q       <= 1'b0;
      rd_addr_q    <= '0;
      core_reset_q <= 1'b1;
      dl_q         <= 1'b0;
      rom_active_q <= 1'b0;
      rom_loaded_q <= 1'b0;
      dip_q        <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      pend_q       <= pend_d;
      rd_addr_q    <= rd_addr_d;
      core_reset_q <= core_reset_d;
      dl_q         <= ioctl_download;
      rom_active_q <= rom_active_d;
      rom_loaded_q <= rom_loaded_d;
      dip_q        <= dip_d;
    end
  end

  // Arbiter FSM with registered SDRAM request and read-return outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      sd_we_q     <= 1'b0;
      sd_rd_q     <= 1'b0;
      sd_addr_q   <= '0;
      sd_din_q    <= '0;
      gfx_data_q  <= '0;
      gfx_valid_q <= 1'b0;
    end else begin
      gfx_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            state_q   <= StWr;
            sd_we_q   <= 1'b1;
            sd_addr_q <= fifo_addr_q[rd_ptr_q];
            sd_din_q  <= fifo_data_q[rd_ptr_q];
          end else if (pend_q) begin
            state_q   <= StRd;
            sd_rd_q   <= 1'b1;
            sd_addr_q <= rd_addr_q;
          end
        end
        StWr: begin
          if (sd_ready) begin
            state_q <= StIdle;
            sd_we_q <= 1'b0;
          end
        end
        StRd: begin
          if (sd_ready) begin
            state_q     <= StIdle;
            sd_rd_q     <= 1'b0;
            gfx_data_q  <= sd_dout;
            gfx_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          sd_we_q <= 1'b0;
          sd_rd_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] rom_sum_q, rom_sum_d;

  // Running sum of accepted ROM bytes, restarted by each ROM download
  always_comb begin
    rom_sum_d = rom_start ? 16'h0000 : rom_sum_q;
    if (push) rom_sum_d = rom_sum_d + {8'h00, ioctl_dout};
  end

  // Checksum register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) rom_sum_q <= '0;
    else          rom_sum_q <= rom_sum_d;
  end

  assign rom_sum = rom_sum_q;
`else
  assign rom_sum = 16'h0000;
`endif

  assign ioctl_wait = (count_q >= CntW'(DEPTH - 2));
  assign dip_out    = dip_q;
  assign gfx_data   = gfx_data_q;
  assign gfx_valid  = gfx_valid_q;
  assign sd_addr    = sd_addr_q;
  assign sd_din     = sd_din_q;
  assign sd_we      = sd_we_q;
  assign sd_rd      = sd_rd_q;
  assign core_reset = core_reset_q;
  assign rom_loaded = rom_loaded_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Bench for ioctl_sdram_loader: scoreboard queues filled by stimulus and a spec-level
// occupancy model, drained by an SDRAM responder and a gfx_valid monitor.
module tb_ioctl_sdram_loader;
  localparam int ADDR_W = 25, DEPTH = 8, ROM_INDEX = 0, DIP_INDEX = 254, DIP_BYTES = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic ioctl_download = 0, ioctl_wr = 0, gfx_read = 0, sd_ready = 0;
  logic [7:0] ioctl_index = 0, ioctl_dout = 0, sd_dout = 0;
  logic [ADDR_W-1:0] ioctl_addr = '0, gfx_addr = '0;
  logic ioctl_wait, gfx_valid, sd_we, sd_rd, core_reset, rom_loaded, overflow;
  logic [8*DIP_BYTES-1:0] dip_out;
  logic [7:0] gfx_data, sd_din;
  logic [ADDR_W-1:0] sd_addr;
  logic [15:0] rom_sum;

  ioctl_sdram_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .ROM_INDEX(ROM_INDEX),
                       .DIP_INDEX(DIP_INDEX), .DIP_BYTES(DIP_BYTES)) dut (
    .clk_sys(clk), .reset_n(rst_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .dip_out(dip_out),
    .gfx_read(gfx_read), .gfx_addr(gfx_addr), .gfx_data(gfx_data), .gfx_valid(gfx_valid),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_we(sd_we), .sd_rd(sd_rd), .sd_dout(sd_dout),
    .sd_ready(sd_ready), .core_reset(core_reset), .rom_loaded(rom_loaded),
    .overflow(overflow), .rom_sum(rom_sum));

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rd_val(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Scoreboard queues and reference state
  logic [ADDR_W+7:0] wq[$];
  logic [ADDR_W-1:0] rq[$];
  logic [7:0]        gq[$];
  logic [8*DIP_BYTES-1:0] exp_dip = '0;
  int occ = 0;
  bit m_ovf = 0, dl_prev = 0;
  logic [15:0] m_sum = 0;

  // Reference model: a ROM byte is accepted iff fewer than DEPTH bytes are outstanding
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ = 0; m_ovf = 0; m_sum = 0; dl_prev = 0; wq.delete();
    end else begin
      if (ioctl_download && !dl_prev && ioctl_index == ROM_INDEX) m_sum = 0;
      dl_prev = ioctl_download;
      if (ioctl_wr && ioctl_download && ioctl_index == ROM_INDEX) begin
        if (occ < DEPTH) begin
          wq.push_back({ioctl_addr, ioctl_dout});
          m_sum = m_sum + 16'(ioctl_dout);
          occ++;
        end else m_ovf = 1;
      end
      if (sd_ready && resp_wr) occ--;
    end
  end

  // SDRAM responder: answers each request after lat_mode cycles (random 0..3 when negative)
  bit resp_en = 1, busy = 0, cap_we = 0, resp_wr = 0, stable_ok = 1, chk_wr_first = 0;
  int lat_mode = 3, wait_cnt = 0, rd_fire_cyc = -10;
  logic [ADDR_W-1:0] cap_addr;
  logic [7:0] cap_din;
  logic [ADDR_W+7:0] e;
  always @(negedge clk) begin
    if (!rst_n) begin
      sd_ready = 0; busy = 0; resp_wr = 0;
    end else if (sd_ready) begin
      sd_ready = 0; busy = 0; resp_wr = 0;
    end else if (resp_en && (sd_we || sd_rd)) begin
      if (!busy) begin
        busy = 1; cap_we = sd_we; cap_addr = sd_addr; cap_din = sd_din; stable_ok = 1;
        wait_cnt = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
      end else if (sd_we !== cap_we || sd_rd !== !cap_we || sd_addr !== cap_addr ||
                   (cap_we && sd_din !== cap_din)) stable_ok = 0;
      if (wait_cnt == 0) begin
        sd_ready = 1; resp_wr = cap_we;
        check("req_stable", stable_ok, 1);
        if (cap_we) begin
          check("wr_expected", wq.size() != 0, 1);
          if (wq.size() != 0) begin
            e = wq.pop_front();
            check("wr_addr", cap_addr, e[ADDR_W+7:8]);
            check("wr_data", cap_din, e[7:0]);
          end
        end else begin
          sd_dout = rd_val(cap_addr);
          check("rd_expected", rq.size() != 0, 1);
          if (rq.size() != 0) check("rd_addr", cap_addr, rq.pop_front());
          if (chk_wr_first) check("wr_before_rd", wq.size(), 0);
          rd_fire_cyc = cyc;
        end
      end else wait_cnt--;
    end
  end

  // Output monitor: back-pressure/overflow every cycle, read returns on gfx_valid
  always @(negedge clk) begin
    check("ioctl_wait", ioctl_wait, occ >= DEPTH - 2);
    check("overflow", overflow, m_ovf);
    if (rst_n && gfx_valid) begin
      check("gfx_expected", gq.size() != 0, 1);
      if (gq.size() != 0) begin
        check("gfx_data", gfx_data, gq.pop_front());
        check("gfx_latency", cyc, rd_fire_cyc + 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit wr, input logic [ADDR_W-1:0] a, input logic [7:0] d,
                       input bit rd, input logic [ADDR_W-1:0] ra, input bit exp_rd);
    ioctl_wr = wr; ioctl_addr = a; ioctl_dout = d; gfx_read = rd; gfx_addr = ra;
    if (exp_rd) begin rq.push_back(ra); gq.push_back(rd_val(ra)); end
    if (wr && ioctl_download && ioctl_index == DIP_INDEX && a < DIP_BYTES)
      exp_dip[8*int'(a) +: 8] = d;
    tick();
    ioctl_wr = 0; gfx_read = 0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ioctl_wait && n < 500) begin tick(); n++; end
    if (n >= 500) check("wait_timeout", ioctl_wait, 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((wq.size() + rq.size() + gq.size()) != 0 && n < 3000) begin tick(); n++; end
    check("drain", wq.size() + rq.size() + gq.size(), 0);
  endtask

  task automatic check_sum(input string name);
`ifdef LOADER_CHECKSUM_EN
    check(name, rom_sum, m_sum);
`else
    check(name, rom_sum, 0);
`endif
  endtask

  task automatic check_reset_vals(input string t);
    check({t, "_ioctl_wait"}, ioctl_wait, 0);  check({t, "_sd_we"}, sd_we, 0);
    check({t, "_sd_rd"}, sd_rd, 0);            check({t, "_gfx_valid"}, gfx_valid, 0);
    check({t, "_rom_loaded"}, rom_loaded, 0);  check({t, "_overflow"}, overflow, 0);
    check({t, "_sd_addr"}, sd_addr, 0);        check({t, "_sd_din"}, sd_din, 0);
    check({t, "_gfx_data"}, gfx_data, 0);      check({t, "_dip_out"}, dip_out, 0);
    check({t, "_rom_sum"}, rom_sum, 0);        check({t, "_core_reset"}, core_reset, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, r;
    bit dw, dr;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    rst_n = 1; tick();

    // DIP capture
    ioctl_index = 8'(DIP_INDEX); ioctl_download = 1; tick();
    for (int k = 0; k < 8; k++) drive(1, ADDR_W'(k), 8'(8'h11 * (k + 1)), 0, '0, 0);
    drive(1, ADDR_W'(8), 8'hFF, 0, '0, 0);
    ioctl_download = 0; tick();
    check("dip_model", dip_out, exp_dip);
    check("dip_const", dip_out, 64'h8877665544332211);

    // ROM stream, fixed 3-cycle latency, honouring back-pressure
    lat_mode = 3; ioctl_index = 8'(ROM_INDEX); ioctl_download = 1; tick(); tick();
    check("core_reset_dl", core_reset, 1);
    for (int i = 0; i < 16; i++) begin
      wait_ready();
      drive(1, ADDR_W'(32'h1000 + i), 8'($urandom), 0, '0, 0);
    end
    ioctl_download = 0; drain(); repeat (4) tick();
    check("rom_loaded", rom_loaded, 1);
    check("core_reset_done", core_reset, 0);
    check_sum("sum_stream");

    // Overflow: SDRAM stalled, 10 pushes ignoring wait
    resp_en = 0; ioctl_download = 1; tick(); tick();
    check("rom_loaded_clr", rom_loaded, 0);
    for (int i = 0; i < 10; i++) drive(1, ADDR_W'(32'h2000 + i), 8'($urandom), 0, '0, 0);
    tick();
    check("ovf_set", overflow, 1);
    ioctl_download = 0; resp_en = 1; lat_mode = -1; drain(); repeat (4) tick();
    check("ovf_sticky", overflow, 1);
    check("rom_loaded_ovf", rom_loaded, 1);

    // Arbitration: read pending while writes queued
    resp_en = 0; ioctl_download = 1; tick();
    for (int i = 0; i < 3; i++) drive(1, ADDR_W'(32'h3000 + i), 8'($urandom), 0, '0, 0);
    ioctl_download = 0; chk_wr_first = 1;
    drive(0, '0, 0, 1, ADDR_W'(32'h100), 1);
    resp_en = 1; lat_mode = 2; drain(); chk_wr_first = 0;
    check("gfx_5a", gfx_data, 8'h5A);

    // Read overwrite before issue
    resp_en = 0; ioctl_download = 1; tick();
    drive(1, ADDR_W'(32'h4000), 8'($urandom), 0, '0, 0);
    ioctl_download = 0;
    drive(0, '0, 0, 1, ADDR_W'(32'h10), 0);
    drive(0, '0, 0, 1, ADDR_W'(32'h20), 1);
    resp_en = 1; lat_mode = 1; drain(); repeat (6) tick();
    check("gfx_latest", gfx_data, 8'h20 ^ 8'h5A);

    // Randomised mix of ROM bytes and reads
    lat_mode = -1; ioctl_index = 8'(ROM_INDEX); ioctl_download = 1; tick();
    for (int i = 0; i < 60; i++) begin
      wait_ready();
      r  = int'($urandom_range(0, 9));
      dw = (r < 6);
      dr = (r >= 4 && r < 7 && rq.size() == 0 && gq.size() == 0);
      drive(dw, ADDR_W'($urandom), 8'($urandom), dr, ADDR_W'($urandom), dr);
    end
    ioctl_download = 0; drain(); repeat (4) tick();
    check("rom_loaded_rand", rom_loaded, 1);
    check("core_reset_rand", core_reset, 0);
    check_sum("sum_rand");

    // Random DIP writes, some out of range
    ioctl_index = 8'(DIP_INDEX); ioctl_download = 1; tick();
    for (int i = 0; i < 8; i++)
      drive(1, ADDR_W'($urandom_range(0, 11)), 8'($urandom), 0, '0, 0);
    ioctl_download = 0; tick();
    check("dip_rand", dip_out, exp_dip);

    // Checksum of two 0xFF bytes
    ioctl_index = 8'(ROM_INDEX); ioctl_download = 1; tick();
    drive(1, ADDR_W'(32'h5000), 8'hFF, 0, '0, 0);
    drive(1, ADDR_W'(32'h5001), 8'hFF, 0, '0, 0);
    ioctl_download = 0; drain(); repeat (4) tick();
`ifdef LOADER_CHECKSUM_EN
    check("sum_ff", rom_sum, 16'h01FE);
`else
    check("sum_ff", rom_sum, 16'h0000);
`endif

    // Reset in the middle of a write
    resp_en = 0; ioctl_download = 1; tick();
    drive(1, ADDR_W'(32'h6000), 8'h33, 0, '0, 0);
    n = 0;
    while (!sd_we && n < 20) begin tick(); n++; end
    check("mid_wr", sd_we, 1);
    ioctl_download = 0;
    rst_n = 0; rq.delete(); gq.delete(); exp_dip = '0;
    #1;
    check_reset_vals("mid_reset");
    tick(); tick();
    rst_n = 1; resp_en = 1;
    repeat (4) tick();
    check("post_reset_idle", sd_we | sd_rd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
